fifo_wr_arbiter: RTL and testbench

Round-robin, burst-locking arbiter that shares the single write port of a `FIFO` (DEPTH-word, 32-bit) between `N_REQ` producers. Each producer presents a valid/ready/last word stream. The arbiter grants one producer at a time for a whole burst and drives the FIFO's `wr_en`/`data_in` directly. It honours FIFO `full` as backpressure and never issues a write while `full` is high.

---
 rtl/fifo_wr_arbiter_pkg.sv | 37 +++
 rtl/fifo_wr_arbiter_if.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the round-robin search helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int N_REQ_MAX = 16;
    localparam int IDX_W_MAX = 4;

    // First set bit of req strictly after last_grant, wrapping modulo n_req.
    // Returns last_grant unchanged when nothing is requesting.
    function automatic logic [IDX_W_MAX-1:0] rr_rotate(
        input logic [N_REQ_MAX-1:0] req,
        input logic [IDX_W_MAX-1:0] last_grant,
        input int                   n_req
    );
        logic [IDX_W_MAX-1:0] winner;
        logic                 found;
        int                   idx;
        winner = last_grant;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ_MAX; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= n_req) begin
                idx = idx - n_req;
            end
            if ((k <= n_req) && !found && (idx < N_REQ_MAX) && req[idx]) begin
                found  = 1'b1;
                winner = idx[IDX_W_MAX-1:0];
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams plus FIFO write port; master is the arbiter side, slave the producers/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_data_in;

    modport master (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_data_in
    );

    modport slave (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest-index requester after last_grant, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             any,
    output logic [IDX_W-1:0] winner
);
    logic [N_REQ_MAX-1:0] req_ext;
    logic [IDX_W_MAX-1:0] last_ext;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ_MAX; gi++) begin : g_req_ext
            if (gi < N_REQ) begin : g_live
                assign req_ext[gi] = req[gi];
            end else begin : g_pad
                assign req_ext[gi] = 1'b0;
            end
        end
        for (gi = 0; gi < IDX_W_MAX; gi++) begin : g_last_ext
            if (gi < IDX_W) begin : g_live
                assign last_ext[gi] = last_grant[gi];
            end else begin : g_pad
                assign last_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign any    = |req;
    assign winner = IDX_W'(rr_rotate(req_ext, last_ext, N_REQ));
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locking round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Optional lock watchdog enabled by defining FIFO_ARB_WDOG_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BURST = 16,
    parameter  int TIMEOUT   = 64,
    localparam int GID_W     = $clog2(N_REQ)
) (
    input  logic               clock,
    input  logic               resetn,
    fifo_wr_arbiter_if.master  bus,
    output logic [GID_W-1:0]   grant_id,
    output logic               busy,
    output logic               timeout_err
);
    localparam int                BEAT_W    = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

    arb_state_e        state_reg, state_next;
    logic [GID_W-1:0]  grant_id_reg, grant_id_next;
    logic [GID_W-1:0]  last_grant_reg, last_grant_next;
    logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic              busy_reg;

    logic              pick_any;
    logic [GID_W-1:0]  pick_winner;
    logic              in_lock;
    logic              lane_valid;
    logic              lane_last;
    logic              transfer;
    logic              burst_end;
    logic              wd_expire;
    logic [DATA_W-1:0] lane_data [N_REQ];

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (GID_W)
    ) u_rr_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant_reg),
        .any        (pick_any),
        .winner     (pick_winner)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign lane_data[gi]     = bus.req_data[gi*DATA_W +: DATA_W];
            assign bus.req_ready[gi] = in_lock && (grant_id_reg == GID_W'(gi)) && !bus.fifo_full;
        end
    endgenerate

    assign in_lock    = (state_reg == LOCK);
    assign lane_valid = bus.req_valid[grant_id_reg];
    assign lane_last  = bus.req_last[grant_id_reg];
    assign transfer   = in_lock && lane_valid && !bus.fifo_full;
    assign burst_end  = transfer && (lane_last || (beat_cnt_reg == BEAT_LAST));

    // Write port rides the handshake directly; data always follows the granted lane.
    assign bus.fifo_wr_en   = transfer;
    assign bus.fifo_data_in = lane_data[grant_id_reg];

`ifdef FIFO_ARB_WDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic            timeout_err_reg;

    // Only cycles where the granted producer has nothing to offer count towards the limit.
    always_comb begin
        wd_cnt_next = wd_cnt_reg;
        wd_expire   = 1'b0;
        if (!in_lock || transfer || bus.fifo_full) begin
            wd_cnt_next = '0;
        end else if (!lane_valid) begin
            if (wd_cnt_reg == WD_LAST) begin
                wd_expire   = 1'b1;
                wd_cnt_next = '0;
            end else begin
                wd_cnt_next = wd_cnt_reg + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            wd_cnt_reg      <= wd_cnt_next;
            timeout_err_reg <= wd_expire;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        grant_id_next   = grant_id_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next      = LOCK;
                    grant_id_next   = pick_winner;
                    last_grant_next = pick_winner;
                    beat_cnt_next   = '0;
                end
            end
            LOCK: begin
                if (transfer) begin
                    beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                end
                if (burst_end || wd_expire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // last_grant resets to the top lane so lane 0 is searched first.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            grant_id_reg   <= '0;
            last_grant_reg <= GID_W'(N_REQ - 1);
            beat_cnt_reg   <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_id_reg   <= grant_id_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
            busy_reg       <= (state_next == LOCK);
        end
    end

    assign grant_id = grant_id_reg;
    assign busy     = busy_reg;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed bursts, expected FIFO writes queued and checked by a monitor.
// Watchdog expectations follow FIFO_ARB_WDOG_EN.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int TO = 64;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct packed {
        logic [1:0]    lane;
        logic [DW-1:0] data;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_err;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BURST (MB),
        .TIMEOUT   (TO)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    word_t  lane_q [N][$];
    exp_t   exp_q[$];
    int     checks      = 0;
    int     failures    = 0;
    int     cyc         = 0;
    int     wr_count    = 0;
    int     last_wr_cyc = 0;
    bit     have_prev   = 0;
    bit     gap_en      = 0;
    int     to_count    = 0;
    int     to_cyc      = 0;
    logic [N-1:0] fire;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_lanes();
        for (int i = 0; i < N; i++) begin
            if (lane_q[i].size() > 0) begin
                bus.req_valid[i]         = 1'b1;
                bus.req_last[i]          = lane_q[i][0].last;
                bus.req_data[i*DW +: DW] = lane_q[i][0].data;
            end else begin
                bus.req_valid[i]         = 1'b0;
                bus.req_last[i]          = 1'b0;
                bus.req_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic push_burst(input int lane, input logic [DW-1:0] base, input int count, input bit last_end);
        word_t w;
        for (int k = 0; k < count; k++) begin
            w.data = base + DW'(k);
            w.last = last_end && (k == count - 1);
            lane_q[lane].push_back(w);
        end
    endtask

    task automatic expect_burst(input int lane, input logic [DW-1:0] base, input int first, input int count);
        exp_t e;
        for (int k = first; k < first + count; k++) begin
            e.lane = 2'(lane);
            e.data = base + DW'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #3;
        resetn = 1'b0;
        for (int i = 0; i < N; i++) lane_q[i].delete();
        exp_q.delete();
        bus.fifo_full = 1'b0;
        gap_en        = 0;
        have_prev     = 0;
        drive_lanes();
        repeat (2) @(posedge clock);
        #3;
        resetn = 1'b1;
    endtask

    // Producer model: a word leaves its lane only on a sampled valid&ready at the edge.
    initial begin
        forever begin
            @(negedge clock);
            fire = bus.req_valid & bus.req_ready;
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
            end
            drive_lanes();
        end
    end

    // Monitor: every FIFO write must match the head of the expected queue.
    always @(negedge clock) begin
        exp_t e;
        if (resetn === 1'b1) begin
            checks++;
            if (!$onehot0(bus.req_ready)) begin
                failures++;
                $display("FAIL ready_onehot actual=%b required=onehot0", bus.req_ready);
            end
            if (bus.fifo_wr_en) begin
                wr_count++;
                checks++;
                if (bus.fifo_full) begin
                    failures++;
                    $display("FAIL write_while_full actual=wr_en=1 required=wr_en=0");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write actual=lane%0d:%h required=none", grant_id, bus.fifo_data_in);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.fifo_data_in !== e.data || grant_id !== e.lane) begin
                        failures++;
                        $display("FAIL fifo_write actual=lane%0d:%h required=lane%0d:%h",
                                 grant_id, bus.fifo_data_in, e.lane, e.data);
                    end else begin
                        $display("write lane%0d data=%h cycle=%0d", grant_id, bus.fifo_data_in, cyc);
                    end
                end
                if (gap_en && have_prev) begin
                    checks++;
                    if (cyc - last_wr_cyc != 2) begin
                        failures++;
                        $display("FAIL write_spacing actual=%0d required=2", cyc - last_wr_cyc);
                    end
                end
                have_prev   = 1;
                last_wr_cyc = cyc;
            end
            if (timeout_err) begin
                to_count++;
                to_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        int base_wr;
        resetn        = 1'b0;
        bus.fifo_full = 1'b0;
        drive_lanes();

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_wr_en", bus.fifo_wr_en, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        @(posedge clock);
        #3;
        resetn = 1'b1;

        // Single 3-beat burst on lane 2
        @(posedge clock);
        #2;
        push_burst(2, 32'hA200_0000, 3, 1);
        expect_burst(2, 32'hA200_0000, 0, 3);
        drive_lanes();
        @(negedge clock);
        chk("t1_ready_idle", bus.req_ready, 4'b0000);
        @(negedge clock);
        chk("t1_arb_latency", bus.req_ready, 4'b0100);
        wait_drain("t1_drain", 30);
        @(posedge clock);
        #1;
        chk("t1_busy_after", busy, 0);

        // Round robin, 1-beat bursts on all lanes
        do_reset();
        @(posedge clock);
        #2;
        gap_en = 1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                push_burst(i, 32'hB000_0000 + DW'(i * 256 + r), 1, 1);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                expect_burst(i, 32'hB000_0000 + DW'(i * 256 + r), 0, 1);
            end
        end
        drive_lanes();
        wait_drain("t2_drain", 60);
        gap_en = 0;

        // Max burst cut on lane 1 with lanes 2 and 3 waiting
        do_reset();
        @(posedge clock);
        #2;
        push_burst(1, 32'h1000_0000, 40, 1);
        push_burst(2, 32'h2222_0000, 1, 1);
        push_burst(3, 32'h3333_0000, 1, 1);
        expect_burst(1, 32'h1000_0000, 0, 16);
        expect_burst(2, 32'h2222_0000, 0, 1);
        expect_burst(3, 32'h3333_0000, 0, 1);
        expect_burst(1, 32'h1000_0000, 16, 16);
        expect_burst(1, 32'h1000_0000, 32, 8);
        drive_lanes();
        wait_drain("t3_drain", 200);

        // FIFO full for 5 cycles mid-burst; beat count must not move during the stall
        do_reset();
        @(posedge clock);
        #2;
        push_burst(0, 32'h4000_0000, 20, 1);
        push_burst(2, 32'h4222_0000, 1, 1);
        expect_burst(0, 32'h4000_0000, 0, 16);
        expect_burst(2, 32'h4222_0000, 0, 1);
        expect_burst(0, 32'h4000_0000, 16, 4);
        drive_lanes();
        repeat (3) @(posedge clock);
        #2;
        bus.fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            chk($sformatf("t4_full_ready_%0d", s), bus.req_ready, 0);
            chk($sformatf("t4_full_wr_en_%0d", s), bus.fifo_wr_en, 0);
        end
        @(posedge clock);
        #2;
        bus.fifo_full = 1'b0;
        wait_drain("t4_drain", 100);

        // Lane 0 locked then drops valid; lane 1 waits
        do_reset();
        @(posedge clock);
        #2;
        push_burst(0, 32'h5000_0000, 1, 0);
        push_burst(1, 32'h5111_0000, 1, 1);
        expect_burst(0, 32'h5000_0000, 0, 1);
`ifdef FIFO_ARB_WDOG_EN
        expect_burst(1, 32'h5111_0000, 0, 1);
`endif
        drive_lanes();
        n = 0;
        while (wr_count == 0 && n < 20) begin
            @(posedge clock);
            n++;
        end
`ifdef FIFO_ARB_WDOG_EN
        n = 0;
        while (to_count == 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk("t5_wd_pulse_seen", to_count, 1);
        // 64 idle cycles after the accepting edge, then the registered pulse
        chk("t5_wd_delay", to_cyc - last_wr_cyc, TO + 1);
        wait_drain("t5_drain", 20);
        repeat (5) @(posedge clock);
        chk("t5_wd_single_pulse", to_count, 1);
`else
        repeat (80) @(negedge clock);
        chk("t5_lock_busy", busy, 1);
        chk("t5_lock_grant", grant_id, 0);
        chk("t5_lock_ready", bus.req_ready, 4'b0001);
        chk("t5_lock_drained", exp_q.size(), 0);
`endif

        // Async reset mid-burst on lane 1
        do_reset();
        @(posedge clock);
        #2;
        push_burst(1, 32'h6000_0000, 10, 1);
        expect_burst(1, 32'h6000_0000, 0, 3);
        drive_lanes();
        base_wr = wr_count;
        n = 0;
        while (wr_count < base_wr + 3 && n < 50) begin
            @(posedge clock);
            n++;
        end
        #2;
        chk("t6_ready_before_rst", bus.req_ready, 4'b0010);
        #1;
        resetn = 1'b0;
        #1;
        chk("t6_rst_ready", bus.req_ready, 0);
        chk("t6_rst_wr_en", bus.fifo_wr_en, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_grant", grant_id, 0);
        push_burst(0, 32'h6AAA_0000, 1, 1);
        push_burst(3, 32'h6333_0000, 1, 1);
        expect_burst(0, 32'h6AAA_0000, 0, 1);
        expect_burst(1, 32'h6000_0000, 3, 7);
        expect_burst(3, 32'h6333_0000, 0, 1);
        drive_lanes();
        repeat (2) @(posedge clock);
        #3;
        resetn = 1'b1;
        wait_drain("t6_drain", 60);

`ifndef FIFO_ARB_WDOG_EN
        chk("no_timeout_pulse", to_count, 0);
`endif
        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
